// File: rtl/fd_pkg.sv
// Shared definitions for the fd_multi clock divider: minimum ratio, default
// ratio width, the ratio-write clamp and the channel-index width helper.
package fd_pkg;

  localparam int FD_MIN_DIV   = 2;
  localparam int FD_DEF_DIV_W = 16;

  // Width of a channel index; never below one bit so a one-channel build has a port.
  function automatic int fd_ch_w(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

  function automatic logic [31:0] fd_clamp(input logic [31:0] d);
    if (d < 32'(FD_MIN_DIV)) begin
      return 32'(FD_MIN_DIV);
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/fd_multi_if.sv
// Control and output bundle of the fd_multi divider; master drives config, slave is the divider.
interface fd_multi_if
  import fd_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = FD_DEF_DIV_W
);
  localparam int CH_W = fd_ch_w(NUM_CH);

  logic [NUM_CH-1:0]       ch_en;
  logic                    cfg_we;
  logic [CH_W-1:0]         cfg_ch;
  logic [DIV_W-1:0]        cfg_div;
  logic                    sync_all;
  logic [NUM_CH-1:0]       out_clk;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH*DIV_W-1:0] cur_div;

  modport master (
    output ch_en, cfg_we, cfg_ch, cfg_div, sync_all,
    input  out_clk, tick, cur_div
  );

  modport slave (
    input  ch_en, cfg_we, cfg_ch, cfg_div, sync_all,
    output out_clk, tick, cur_div
  );

endinterface

// File: rtl/fd_chan.sv
// One divider channel: counter, active/shadow ratios, registered divided clock
// and period-start tick (tick flop only present when FD_TICK_EN is defined).
module fd_chan
  import fd_pkg::*;
#(
  parameter int DIV_W   = FD_DEF_DIV_W,
  parameter int DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             we,
  input  logic [DIV_W-1:0] div,
  input  logic             sync,
  output logic             out_clk,
  output logic             tick,
  output logic [DIV_W-1:0] act
);

  localparam logic [DIV_W-1:0] DEF_R  = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] ZERO_R = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] ONE_R  = DIV_W'(1);

  logic [DIV_W-1:0] cnt_r, act_r, shadow_r;
  logic [DIV_W-1:0] div_c_s, cnt_inc_s, cnt_n_s, act_n_s, shadow_n_s;
  logic             out_r, out_n_s, wrap_s;

  // Next-state for counter, ratios and divided clock.
  always_comb begin
    div_c_s    = DIV_W'(fd_clamp(32'(div)));
    shadow_n_s = we ? div_c_s : shadow_r;
    cnt_inc_s  = (cnt_r == act_r - ONE_R) ? ZERO_R : cnt_r + ONE_R;
    wrap_s     = (cnt_inc_s == ZERO_R);
    cnt_n_s    = cnt_r;
    act_n_s    = act_r;
    out_n_s    = out_r;
    // A stopped or re-aligned channel parks at cnt=0 and picks up the newest ratio.
    if (!en || sync) begin
      cnt_n_s = ZERO_R;
      out_n_s = 1'b0;
      act_n_s = shadow_n_s;
    end else begin
      cnt_n_s = cnt_inc_s;
      out_n_s = (cnt_inc_s < (act_r >> 1));
      if (wrap_s) begin
        act_n_s = shadow_n_s;
      end else begin
        act_n_s = act_r;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= ZERO_R;
      act_r    <= DEF_R;
      shadow_r <= DEF_R;
      out_r    <= 1'b0;
    end else begin
      cnt_r    <= cnt_n_s;
      act_r    <= act_n_s;
      shadow_r <= shadow_n_s;
      out_r    <= out_n_s;
    end
  end

`ifdef FD_TICK_EN
  logic tick_r;

  // Period-start pulse, coincident with the rising edge of out_clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_r <= 1'b0;
    end else begin
      tick_r <= en & ~sync & wrap_s;
    end
  end

  assign tick = tick_r;
`else
  assign tick = 1'b0;
`endif

  assign out_clk = out_r;
  assign act     = act_r;

endmodule

// File: rtl/fd_multi.sv
// Multi-channel programmable clock divider top: decodes config writes and
// fans sync_all out to NUM_CH fd_chan slices. Optional tick outputs: FD_TICK_EN.
module fd_multi
  import fd_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DIV_W   = FD_DEF_DIV_W,
  parameter int DEF_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  fd_multi_if.slave  bus
);

  localparam int CH_W = fd_ch_w(NUM_CH);

  logic [NUM_CH-1:0]       we_s;
  logic [NUM_CH-1:0]       out_clk_s;
  logic [NUM_CH-1:0]       tick_s;
  logic [NUM_CH*DIV_W-1:0] cur_div_s;

  // An out-of-range cfg_ch matches no slice, so the write is dropped.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign we_s[g] = bus.cfg_we & (bus.cfg_ch == CH_W'(g));

    fd_chan #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (bus.ch_en[g]),
      .we      (we_s[g]),
      .div     (bus.cfg_div),
      .sync    (bus.sync_all),
      .out_clk (out_clk_s[g]),
      .tick    (tick_s[g]),
      .act     (cur_div_s[g*DIV_W +: DIV_W])
    );
  end

  assign bus.out_clk = out_clk_s;
  assign bus.tick    = tick_s;
  assign bus.cur_div = cur_div_s;

endmodule

// File: tb/tb_fd_multi.sv
// Self-checking bench for fd_multi: per-cycle scoreboard against a reference
// model, a config-write vector table and hand-written corner sequences.
module tb_fd_multi;
  import fd_pkg::*;

  localparam int NUM_CH  = 5;
  localparam int DIV_W   = 16;
  localparam int DEF_DIV = 4;
  localparam int CDW     = NUM_CH * DIV_W;

  typedef struct {
    logic [NUM_CH-1:0] oc;
    logic [NUM_CH-1:0] tk;
    logic [CDW-1:0]    cd;
  } exp_t;

  typedef struct {
    logic           we;
    logic [2:0]     ch;
    logic [15:0]    div;
    int             idle;
    logic [CDW-1:0] cd;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fd_multi_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

  fd_multi #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int   m_cnt [NUM_CH];
  int   m_act [NUM_CH];
  int   m_sh  [NUM_CH];
  logic m_out [NUM_CH];
  logic m_tk  [NUM_CH];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [CDW-1:0] got, input logic [CDW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_cnt[i] = 0;
      m_act[i] = DEF_DIV;
      m_sh[i]  = DEF_DIV;
      m_out[i] = 1'b0;
      m_tk[i]  = 1'b0;
    end
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  function automatic void model_step();
    int nsh, nx;
    for (int i = 0; i < NUM_CH; i++) begin
      nsh = m_sh[i];
      if (bus.cfg_we && (int'(bus.cfg_ch) == i))
        nsh = (int'(bus.cfg_div) < 2) ? 2 : int'(bus.cfg_div);
      if (!bus.ch_en[i] || bus.sync_all) begin
        m_cnt[i] = 0;
        m_out[i] = 1'b0;
        m_tk[i]  = 1'b0;
        m_act[i] = nsh;
      end else begin
        nx = (m_cnt[i] + 1) % m_act[i];
        m_out[i] = (nx < m_act[i] / 2);
        m_tk[i]  = (nx == 0);
        if (nx == 0) m_act[i] = nsh;
        m_cnt[i] = nx;
      end
      m_sh[i] = nsh;
    end
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    for (int i = 0; i < NUM_CH; i++) begin
      e.oc[i] = m_out[i];
`ifdef FD_TICK_EN
      e.tk[i] = m_tk[i];
`else
      e.tk[i] = 1'b0;
`endif
      e.cd[i*DIV_W +: DIV_W] = DIV_W'(m_act[i]);
    end
    return e;
  endfunction

  task automatic cycle();
    exp_t e;
    model_step();
    sb.push_back(model_exp());
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("sb_out_clk", CDW'(bus.out_clk), CDW'(e.oc));
    chk("sb_tick", CDW'(bus.tick), CDW'(e.tk));
    chk("sb_cur_div", bus.cur_div, e.cd);
  endtask

  vec_t vecs[7];
  logic [CDW-1:0] all_def;
  bit   oc4[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  bit   tk4[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  bit   oc8[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                    1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic default_pattern(input string nm);
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk({nm, "_oc0"}, CDW'(bus.out_clk[0]), CDW'(oc4[k]));
`ifdef FD_TICK_EN
      chk({nm, "_tk0"}, CDW'(bus.tick[0]), CDW'(tk4[k]));
`else
      chk({nm, "_tk0"}, CDW'(bus.tick[0]), CDW'(1'b0));
`endif
    end
  endtask

  initial begin
    int found;
    logic [NUM_CH-1:0] prev, rise;

    for (int i = 0; i < NUM_CH; i++) all_def[i*DIV_W +: DIV_W] = 16'd4;
    vecs[0] = '{1'b0, 3'd0, 16'd0, 8,  {16'd4, 16'd4, 16'd4, 16'd4, 16'd4}};
    vecs[1] = '{1'b1, 3'd1, 16'd5, 10, {16'd4, 16'd4, 16'd4, 16'd5, 16'd4}};
    vecs[2] = '{1'b1, 3'd2, 16'd0, 10, {16'd4, 16'd4, 16'd2, 16'd5, 16'd4}};
    vecs[3] = '{1'b1, 3'd2, 16'd1, 10, {16'd4, 16'd4, 16'd2, 16'd5, 16'd4}};
    vecs[4] = '{1'b1, 3'd7, 16'd9, 10, {16'd4, 16'd4, 16'd2, 16'd5, 16'd4}};
    vecs[5] = '{1'b1, 3'd5, 16'd9, 10, {16'd4, 16'd4, 16'd2, 16'd5, 16'd4}};
    vecs[6] = '{1'b1, 3'd4, 16'd6, 12, {16'd6, 16'd4, 16'd2, 16'd5, 16'd4}};

    bus.ch_en    = '0;
    bus.cfg_we   = 1'b0;
    bus.cfg_ch   = 3'd0;
    bus.cfg_div  = 16'd0;
    bus.sync_all = 1'b0;
    model_reset();

    #12;
    chk("rst_out_clk", CDW'(bus.out_clk), {CDW{1'b0}});
    chk("rst_tick", CDW'(bus.tick), {CDW{1'b0}});
    chk("rst_cur_div", bus.cur_div, all_def);

    @(negedge clk);
    rst_n = 1'b1;
    bus.ch_en = '1;
    default_pattern("dflt");

    for (int v = 0; v < 7; v++) begin
      bus.cfg_we  = vecs[v].we;
      bus.cfg_ch  = vecs[v].ch;
      bus.cfg_div = vecs[v].div;
      cycle();
      bus.cfg_we = 1'b0;
      for (int k = 0; k < vecs[v].idle; k++) cycle();
      chk($sformatf("vec%0d_cur_div", v), bus.cur_div, vecs[v].cd);
    end

    // Ratios 3,4,6,7 on channels 0..3, then phase-align them.
    for (int i = 0; i < 4; i++) begin
      bus.cfg_we  = 1'b1;
      bus.cfg_ch  = 3'(i);
      bus.cfg_div = (i == 0) ? 16'd3 : (i == 1) ? 16'd4 : (i == 2) ? 16'd6 : 16'd7;
      cycle();
    end
    bus.cfg_we   = 1'b0;
    bus.sync_all = 1'b1;
    cycle();
    bus.sync_all = 1'b0;
    chk("sync_out_clk", CDW'(bus.out_clk), {CDW{1'b0}});
    chk("sync_cur_div", CDW'(bus.cur_div[63:0]), CDW'({16'd7, 16'd6, 16'd4, 16'd3}));
    found = 0;
    for (int k = 1; k <= 120; k++) begin
      prev = bus.out_clk;
      cycle();
      rise = ~prev & bus.out_clk;
      if (found == 0 && rise[3:0] == 4'hF) found = k;
    end
    chk("lcm_align", CDW'(found), CDW'(84));

    // Channel 0 stopped, reprogrammed while stopped, then restarted.
    bus.ch_en = 5'b11110;
    cycle();
    cycle();
    bus.cfg_we  = 1'b1;
    bus.cfg_ch  = 3'd0;
    bus.cfg_div = 16'd8;
    cycle();
    bus.cfg_we = 1'b0;
    for (int k = 0; k < 7; k++) cycle();
    chk("dis_out_clk0", CDW'(bus.out_clk[0]), CDW'(1'b0));
    chk("dis_cur_div0", CDW'(bus.cur_div[15:0]), CDW'(16'd8));
    bus.ch_en = '1;
    for (int k = 0; k < 15; k++) begin
      cycle();
      chk("reen_oc0", CDW'(bus.out_clk[0]), CDW'(oc8[k]));
    end

    // Asynchronous reset in the middle of a period.
    cycle();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_clk", CDW'(bus.out_clk), {CDW{1'b0}});
    chk("arst_tick", CDW'(bus.tick), {CDW{1'b0}});
    chk("arst_cur_div", bus.cur_div, all_def);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    default_pattern("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
